dsm_stereo_decimator: RTL and testbench
=======================================

# dsm_stereo_decimator

Stereo delta-sigma receiver. It converts two 1-bit delta-sigma bitstreams back into DSM_WIDTH-bit unsigned PCM samples using a second-order CIC (sinc²) decimator per channel. It is the return direction of `dsm_stereo`: it sits behind an external 1-bit modulator or comparator front end, and it loops back `dsm_stereo` outputs for self-test.

## Interface
- `DSM_WIDTH`, default 12: PCM width. Must be even.
  - Decimation ratio R = 2^(DSM_WIDTH/2), 64 at the default.
  - CIC gain R² = 2^DSM_WIDTH.
- `aclr` input, 1 bit: reset, asynchronous and active-high. Clears every register.
- `clk` input, 1 bit: single clock. The bitstreams are sampled on its rising edge.
- `left_in` input, 1 bit: left bitstream. 1 = full-scale positive density.
- `right_in` input, 1 bit: right bitstream.
- `left_pcm` output, DSM_WIDTH bits: left decimated sample. Registered.
- `right_pcm` output, DSM_WIDTH bits: right decimated sample. Registered.
- `sample_valid` output, 1 bit: one-cycle strobe. Asserted when both `*_pcm` outputs load a new sample.

## Operation
- **Word width.** CIC width is W = DSM_WIDTH + 1 bits (13 at the default). All integrator and comb arithmetic is unsigned modulo 2^W; wrap-around is intended and exact.
- **Per channel, every clock:**
  - `integ1 <= integ1 + in`
  - `integ2 <= integ2 + integ1`, using the old `integ1`.
- **Phase counter.** Shared by both channels, DSM_WIDTH/2 bits, runs 0..R-1 and wraps.
- **Decimation edge.** A decimation edge is a rising edge at which phase == R-1. On it:
  - `s = integ2` (pre-update value)
  - `c1 = s - s_d`, then `s_d <= s`
  - `c2 = c1 - c1_d`, then `c1_d <= c1`
  - `c2` is registered into `comb_out`.
- **Output edge.** This is the edge after a decimation edge.
  - `*_pcm <= sat(comb_out)`, where `sat` maps 2^DSM_WIDTH to 2^DSM_WIDTH-1. Any other value passes unchanged; for valid bitstreams `comb_out` never exceeds 2^DSM_WIDTH.
  - `sample_valid` is high for that single cycle, provided warm-up is complete.
- **Warm-up state machine.** Two states, WARMUP and RUN.
  - WARMUP holds a 2-bit count of decimation edges.
  - It moves to RUN on the 2nd decimation edge. The first two comb results are discarded: `*_pcm` is not loaded and `sample_valid` stays low.
  - RUN is held until `aclr`.
- **Channels.** Left and right are processed identically and in lockstep. They share the phase counter, warm-up state and `sample_valid`.
- **Mid-operation reset.** `aclr` at any time returns the block to the reset state below immediately. The next sample is produced only after a full warm-up again.

## Timing
- **Reset values.**
  - `left_pcm` = 0, `right_pcm` = 0, `sample_valid` = 0.
  - Phase = 0, state = WARMUP.
  - Integrators, comb delays and `comb_out` = 0.
- **Edge numbering.** Count edges from 1 after `aclr` deasserts.
  - Decimation edges fall at k·R.
  - The first `sample_valid` pulse is driven by edge 3R+1. After that, one pulse every R clocks.
- **Between pulses.** `*_pcm` holds its value.
- **Latency and settling.**
  - An input step reaches its final value at the 2nd output after the decimation window containing the step; sinc² settles in 2 windows.
  - Pipeline latency is 1 clock from decimation edge to output.
- **Throughput.** One stereo sample per R clocks. No backpressure; downstream must accept every strobe.

## Structure
- **Shared package `dsm_pkg`.** Holds the items shared with `dsm_stereo`:
  - `DSM_WIDTH` default
  - derived `DSM_DECIM_LOG2 = DSM_WIDTH/2`
  - CIC word width `DSM_WIDTH + 1`
  - saturation maximum constant
- **Sub-module `cic2_decim`.** One channel: integrators, comb pipeline, saturation. It is parameterised by `DSM_WIDTH`, takes the shared decimation strobe and output-load enable, and is instantiated twice.
- **Top level.** Holds the phase counter, warm-up FSM and `sample_valid`.

## Test plan
All scenarios use the default `DSM_WIDTH` = 12, R = 64, with a 20 ns clock.
- **Reset and first strobe.**
  - Stimulus: `aclr` pulse, both inputs held at 0.
  - Response: outputs stay 0. First `sample_valid` pulse on edge 193, then every 64 clocks. Both pcm = 0.
- **Full scale and saturation.**
  - Stimulus: `left_in` = 1 constant, `right_in` = 0.
  - Response: from the first strobe, `left_pcm` = 4095 (saturated from 4096) and `right_pcm` = 0.
- **Loopback, exact tone.**
  - Stimulus: `dsm_stereo` (`DSM_WIDTH` 12) driving the inputs, right = 1024, left = 2048.
  - Response: after 2 strobes of settling, `right_pcm` = 1024 and `left_pcm` = 2048 exactly, on every strobe.
- **Loopback, irregular values.**
  - Stimulus: the same loopback with left = 127, right = 3750.
  - Response: every settled strobe lies within ±128 of 127 and 3750 respectively. The average over 64 strobes is within ±2.
- **Step change.**
  - Stimulus: loopback with right switching 0 → 1024 at an arbitrary phase.
  - Response: the 2nd strobe after the window containing the switch reads 1024. The intermediate strobe lies within [0, 1024].
- **Mid-operation reset.**
  - Stimulus: `aclr` pulsed during RUN, at phase 30.
  - Response: pcm = 0 and `sample_valid` = 0 immediately. The next strobe comes 3R+1 edges after release.

Source files
------------

// File: rtl/dsm_pkg.sv
// Items shared between the stereo delta-sigma modulator and its decimating receiver.
package dsm_pkg;

  // Default PCM width; must be even so that R = 2^(DSM_WIDTH/2) is a power of two.
  localparam int DSM_WIDTH_DEFAULT = 12;

  // log2 of the decimation ratio.
  localparam int DSM_DECIM_LOG2 = DSM_WIDTH_DEFAULT / 2;

  // CIC word width: one bit above PCM, so the full-scale result R^2 fits.
  localparam int DSM_CIC_W = DSM_WIDTH_DEFAULT + 1;

  // Largest representable PCM code; full-scale CIC output is clamped to this.
  localparam int DSM_SAT_MAX = (1 << DSM_WIDTH_DEFAULT) - 1;

  // Receiver warm-up state.
  typedef enum logic {
    ST_WARMUP = 1'b0,
    ST_RUN    = 1'b1
  } dsm_state_e;

endpackage

// File: rtl/dsm_stereo_decimator_if.sv
// Bitstream inputs and PCM outputs of the stereo decimator.
interface dsm_stereo_decimator_if
  import dsm_pkg::*;
#(
  parameter int DSM_WIDTH = DSM_WIDTH_DEFAULT
);
  logic                 left_in;
  logic                 right_in;
  logic [DSM_WIDTH-1:0] left_pcm;
  logic [DSM_WIDTH-1:0] right_pcm;
  logic                 sample_valid;

  // Source side: drives the bitstreams, consumes the samples.
  modport master (
    output left_in, right_in,
    input  left_pcm, right_pcm, sample_valid
  );

  // Decimator side.
  modport slave (
    input  left_in, right_in,
    output left_pcm, right_pcm, sample_valid
  );
endinterface

// File: rtl/cic2_decim.sv
// One channel of the sinc^2 decimator: two integrators at the input rate, two
// combs at the decimated rate, then saturation into the PCM register.
module cic2_decim
  import dsm_pkg::*;
#(
  parameter int DSM_WIDTH = DSM_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 din,
  input  logic                 dec_stb,
  input  logic                 ld_en,
  output logic [DSM_WIDTH-1:0] pcm
);
  localparam int W = DSM_WIDTH + 1;

  logic [W-1:0]         integ1_q, integ1_d;
  logic [W-1:0]         integ2_q, integ2_d;
  logic [W-1:0]         sdly_q, sdly_d;
  logic [W-1:0]         c1dly_q, c1dly_d;
  logic [W-1:0]         comb_q, comb_d;
  logic [DSM_WIDTH-1:0] pcm_q, pcm_d;
  logic [W-1:0]         c1, c2;

  // Integrators run every clock; combs and PCM load only on their strobes.
  // Modular wrap in the integrators is exact because the combs undo it.
  always_comb begin
    integ1_d = integ1_q + {{(W-1){1'b0}}, din};
    integ2_d = integ2_q + integ1_q;
    c1       = integ2_q - sdly_q;
    c2       = c1 - c1dly_q;
    sdly_d   = sdly_q;
    c1dly_d  = c1dly_q;
    comb_d   = comb_q;
    pcm_d    = pcm_q;
    if (dec_stb) begin
      sdly_d  = integ2_q;
      c1dly_d = c1;
      comb_d  = c2;
    end
    // Only R^2 itself sets the top bit for a legal bitstream; clamp it to all-ones.
    if (ld_en) pcm_d = comb_q[W-1] ? '1 : comb_q[DSM_WIDTH-1:0];
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      integ1_q <= '0;
      integ2_q <= '0;
      sdly_q   <= '0;
      c1dly_q  <= '0;
      comb_q   <= '0;
      pcm_q    <= '0;
    end else begin
      integ1_q <= integ1_d;
      integ2_q <= integ2_d;
      sdly_q   <= sdly_d;
      c1dly_q  <= c1dly_d;
      comb_q   <= comb_d;
      pcm_q    <= pcm_d;
    end
  end

  assign pcm = pcm_q;

endmodule

// File: rtl/dsm_stereo_decimator.sv
// Stereo delta-sigma receiver: shared phase counter and warm-up control driving
// two lockstep sinc^2 channels.
module dsm_stereo_decimator
  import dsm_pkg::*;
#(
  parameter int DSM_WIDTH = DSM_WIDTH_DEFAULT
) (
  input logic                   clk,
  input logic                   aclr,
  dsm_stereo_decimator_if.slave bus
);
  localparam int PH_W = DSM_WIDTH / 2;
  localparam logic [PH_W-1:0] PH_LAST = '1;

  logic [PH_W-1:0] ph_q, ph_d;
  dsm_state_e      st_q, st_d;
  logic [1:0]      wcnt_q, wcnt_d;
  // [1]: load PCM on the next edge, [2]: sample_valid.
  logic [2:1]      vld_pipe_q, vld_pipe_d;
  logic            dec_stb;

  assign dec_stb = (ph_q == PH_LAST);

  // Phase wrap, warm-up counting and the strobe pipeline. The first two comb
  // results are still filling the comb delays, so they never reach the outputs.
  always_comb begin
    ph_d   = ph_q + 1'b1;
    st_d   = st_q;
    wcnt_d = wcnt_q;
    if (dec_stb && (st_q == ST_WARMUP)) begin
      wcnt_d = wcnt_q + 2'd1;
      if (wcnt_q == 2'd1) st_d = ST_RUN;
    end
    vld_pipe_d[1] = dec_stb && (st_q == ST_RUN);
    vld_pipe_d[2] = vld_pipe_q[1];
  end

  // Control registers.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      ph_q       <= '0;
      st_q       <= ST_WARMUP;
      wcnt_q     <= '0;
      vld_pipe_q <= '0;
    end else begin
      ph_q       <= ph_d;
      st_q       <= st_d;
      wcnt_q     <= wcnt_d;
      vld_pipe_q <= vld_pipe_d;
    end
  end

  assign bus.sample_valid = vld_pipe_q[2];

  cic2_decim #(.DSM_WIDTH(DSM_WIDTH)) u_left (
    .clk     (clk),
    .aclr    (aclr),
    .din     (bus.left_in),
    .dec_stb (dec_stb),
    .ld_en   (vld_pipe_q[1]),
    .pcm     (bus.left_pcm)
  );

  cic2_decim #(.DSM_WIDTH(DSM_WIDTH)) u_right (
    .clk     (clk),
    .aclr    (aclr),
    .din     (bus.right_in),
    .dec_stb (dec_stb),
    .ld_en   (vld_pipe_q[1]),
    .pcm     (bus.right_pcm)
  );

endmodule

// File: tb/tb_dsm_stereo_decimator.sv
// Bench for the stereo decimator: every output is checked each cycle against a
// triangular-FIR model of sinc^2 applied to the recorded bitstreams.
module tb_dsm_stereo_decimator;
  localparam int W    = 12;
  localparam int R    = 64;
  localparam int NB   = 1 << W;
  localparam int HMAX = 8192;

  logic clk;
  logic aclr = 1'b0;

  dsm_stereo_decimator_if #(.DSM_WIDTH(W)) dif ();

  dsm_stereo_decimator #(.DSM_WIDTH(W)) dut (
    .clk  (clk),
    .aclr (aclr),
    .bus  (dif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Bitstream history indexed by clock edge number since reset release.
  bit xl[HMAX];
  bit xr[HMAX];
  int edge_n;
  int first_edge;
  int held_l, held_r;
  int sl[$];
  int sr[$];

  // Source: 0 = constant bit, 1 = first-order delta-sigma of a PCM value, 2 = random density.
  int mode, lval, rval, accl, accr;

  typedef struct {
    int mode;
    int l;
    int r;
    int nstb;
    int skip;
    int exp_l;
    int exp_r;
    int tol;
  } vec_t;
  vec_t vt[6];

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", nm, edge_n, act, exp);
    end
  endtask

  task automatic chk_rng(string nm, int act, int lo, int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s actual=%0d required=[%0d,%0d]", nm, act, lo, hi);
    end
  endtask

  // sinc^2 as a triangular FIR: output at decimation n weights the sample at
  // edge nR-1-D by min(D, 2R-D) for D in 1..2R-1.
  function automatic int model(int n, bit ch);
    int s = 0;
    for (int d = 1; d < 2*R; d++) begin
      int j = n*R - 1 - d;
      int w = (d <= R) ? d : 2*R - d;
      if (j >= 1) s += w * (ch ? int'(xr[j]) : int'(xl[j]));
    end
    if (s >= NB) s = NB - 1;
    return s;
  endfunction

  task automatic gen_bits();
    case (mode)
      0: begin
        dif.left_in  = lval[0];
        dif.right_in = rval[0];
      end
      1: begin
        accl += lval;
        accr += rval;
        dif.left_in  = (accl >= NB);
        dif.right_in = (accr >= NB);
        if (accl >= NB) accl -= NB;
        if (accr >= NB) accr -= NB;
      end
      default: begin
        dif.left_in  = ($urandom_range(NB-1) < lval);
        dif.right_in = ($urandom_range(NB-1) < rval);
      end
    endcase
  endtask

  // One clock: present inputs, record them, then check outputs 1 ns after the edge.
  task automatic step();
    bit ev;
    gen_bits();
    @(posedge clk);
    edge_n++;
    if (edge_n < HMAX) begin
      xl[edge_n] = dif.left_in;
      xr[edge_n] = dif.right_in;
    end
    #1;
    ev = (edge_n >= 3*R+1) && ((edge_n-1) % R == 0);
    chk("sample_valid", int'(dif.sample_valid), int'(ev));
    if (dif.sample_valid && first_edge < 0) first_edge = edge_n;
    if (ev) begin
      held_l = model((edge_n-1)/R, 1'b0);
      held_r = model((edge_n-1)/R, 1'b1);
      sl.push_back(int'(dif.left_pcm));
      sr.push_back(int'(dif.right_pcm));
    end
    chk("left_pcm", int'(dif.left_pcm), held_l);
    chk("right_pcm", int'(dif.right_pcm), held_r);
  endtask

  task automatic run_strobes(int n);
    int budget = 3*R + 1 + (n+1)*R;
    while (sl.size() < n && budget > 0) begin
      step();
      budget--;
    end
    if (sl.size() < n) chk("strobe_timeout", sl.size(), n);
  endtask

  // Assert reset (possibly mid-cycle), check the cleared outputs, release on a falling edge.
  task automatic do_reset();
    dif.left_in  = 1'b0;
    dif.right_in = 1'b0;
    aclr = 1'b1;
    #1;
    chk("rst_left_pcm", int'(dif.left_pcm), 0);
    chk("rst_right_pcm", int'(dif.right_pcm), 0);
    chk("rst_valid", int'(dif.sample_valid), 0);
    @(negedge clk);
    @(negedge clk);
    aclr = 1'b0;
    edge_n = 0;
    first_edge = -1;
    held_l = 0;
    held_r = 0;
    accl = 0;
    accr = 0;
    sl.delete();
    sr.delete();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sum_l, sum_r, cnt, e0, m;
    vt[0] = '{0, 0,    0,    4,  0, 0,    0,    0};
    vt[1] = '{0, 1,    0,    4,  0, 4095, 0,    0};
    vt[2] = '{0, 0,    1,    3,  0, 0,    4095, 0};
    vt[3] = '{1, 2048, 1024, 6,  2, 2048, 1024, 0};
    vt[4] = '{1, 1024, 3072, 5,  2, 1024, 3072, 0};
    vt[5] = '{1, 127,  3750, 66, 2, 127,  3750, 128};

    edge_n = 0;
    mode = 0; lval = 0; rval = 0;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      mode = vt[v].mode;
      lval = vt[v].l;
      rval = vt[v].r;
      run_strobes(vt[v].nstb);
      chk("first_strobe_edge", first_edge, 3*R+1);
      sum_l = 0; sum_r = 0; cnt = 0;
      for (int i = vt[v].skip; i < sl.size(); i++) begin
        chk_rng("vec_left", sl[i], vt[v].exp_l - vt[v].tol, vt[v].exp_l + vt[v].tol);
        chk_rng("vec_right", sr[i], vt[v].exp_r - vt[v].tol, vt[v].exp_r + vt[v].tol);
        sum_l += sl[i];
        sum_r += sr[i];
        cnt++;
      end
      chk_rng("avg_left_x_cnt", sum_l, (vt[v].exp_l-2)*cnt, (vt[v].exp_l+2)*cnt);
      chk_rng("avg_right_x_cnt", sum_r, (vt[v].exp_r-2)*cnt, (vt[v].exp_r+2)*cnt);
    end

    // Step 0 -> 1024 on the right channel at an arbitrary edge.
    do_reset();
    mode = 1; lval = 0; rval = 0;
    e0 = 4*R + 1 + int'($urandom_range(2*R-1));
    while (edge_n < e0 - 1) step();
    rval = 1024;
    m = (e0 + R - 1) / R;
    run_strobes(m);
    if (sr.size() >= m) begin
      chk("step_settled", sr[m-1], 1024);
      chk_rng("step_intermediate", sr[m-2], 0, 1024);
    end

    // Random densities, changed partway through.
    for (int t = 0; t < 3; t++) begin
      do_reset();
      mode = 2;
      lval = int'($urandom_range(NB));
      rval = int'($urandom_range(NB));
      run_strobes(3);
      lval = int'($urandom_range(NB));
      rval = int'($urandom_range(NB));
      run_strobes(6);
    end

    // Reset during RUN at phase 30: outputs clear at once, full warm-up follows.
    do_reset();
    mode = 0; lval = 1; rval = 1;
    run_strobes(2);
    chk("pre_reset_left", int'(dif.left_pcm), 4095);
    while (edge_n % R != 30) step();
    #5;
    do_reset();
    mode = 0; lval = 1; rval = 0;
    run_strobes(2);
    chk("reset_first_strobe_edge", first_edge, 3*R+1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
